// File: rtl/alsu_param.sv
// alsu_param: two-stage pipelined WIDTH-bit arithmetic/logic/shift unit with a saturating error counter.
// Build option: define ALSU_LED_BLINK_EN to blink leds (instead of holding all-ones) while an error is flagged.

module alsu_param #(
    parameter int WIDTH          = 3,
    parameter int LED_W          = 16,
    parameter int FULL_ADDER     = 1,
    parameter int INPUT_PRIORITY = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [2:0]         opcode,
    input  logic               cin,
    input  logic               serial_in,
    input  logic               direction,
    input  logic               red_op_A,
    input  logic               red_op_B,
    input  logic               bypass_A,
    input  logic               bypass_B,
    output logic [2*WIDTH-1:0] out,
    output logic               out_valid,
    output logic [LED_W-1:0]   leds,
    output logic [7:0]         err_cnt
);

    localparam int OW = 2 * WIDTH;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_XOR   = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_MUL   = 3'd3;
    localparam logic [2:0] OP_SHIFT = 3'd4;
    localparam logic [2:0] OP_ROT   = 3'd5;

    localparam logic [LED_W-1:0] LED_ON = '1;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       opcode;
        logic             cin;
        logic             serial_in;
        logic             direction;
        logic             red_a;
        logic             red_b;
        logic             byp_a;
        logic             byp_b;
    } s1_t;

    s1_t              s1_q, s1_d;
    logic             s1_valid_q, s1_valid_d;
    logic [OW-1:0]    out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q, err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [LED_W-1:0] leds_q, leds_d;

    logic             invalid;
    logic             sel_b_byp;
    logic             sel_b_red;
    logic             red_bit;
    logic [WIDTH-1:0] byp_opnd;
    logic [WIDTH-1:0] red_opnd;
    logic [WIDTH:0]   sum;
    logic [OW-1:0]    prod;
    logic [OW-1:0]    result;

    always_comb begin : stage1_next
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        s1_d       = s1_q;
        s1_valid_d = in_valid;
        if (in_valid) begin
            s1_d.a         = A;
            s1_d.b         = B;
            s1_d.opcode    = opcode;
            s1_d.cin       = cin;
            s1_d.serial_in = serial_in;
            s1_d.direction = direction;
            s1_d.red_a     = red_op_A;
            s1_d.red_b     = red_op_B;
            s1_d.byp_a     = bypass_A;
            s1_d.byp_b     = bypass_B;
        end
    end

    always_comb begin : stage2_compute
        invalid   = (s1_q.opcode inside {3'd6, 3'd7}) ||
                    ((s1_q.red_a || s1_q.red_b) && !(s1_q.opcode inside {OP_AND, OP_XOR}));
        sel_b_byp = s1_q.byp_b && (!s1_q.byp_a || INPUT_PRIORITY != 0);
        byp_opnd  = sel_b_byp ? s1_q.b : s1_q.a;
        sel_b_red = s1_q.red_b && (!s1_q.red_a || INPUT_PRIORITY != 0);
        red_opnd  = sel_b_red ? s1_q.b : s1_q.a;
        red_bit   = (s1_q.opcode == OP_XOR) ? ^red_opnd : &red_opnd;
        sum       = {1'b0, s1_q.a} + {1'b0, s1_q.b} +
                    {{WIDTH{1'b0}}, (FULL_ADDER != 0) && s1_q.cin};
        prod      = {{WIDTH{1'b0}}, s1_q.a} * {{WIDTH{1'b0}}, s1_q.b};

        result = out_q;
        if (s1_q.byp_a || s1_q.byp_b) begin
            result = {{WIDTH{1'b0}}, byp_opnd};
        end else if (s1_q.red_a || s1_q.red_b) begin
            result = {{(OW-1){1'b0}}, red_bit};
        end else begin
            // Shift and rotate act on the live out_q, so back-to-back ops chain naturally.
            case (s1_q.opcode)
                OP_AND:   result = {{WIDTH{1'b0}}, s1_q.a & s1_q.b};
                OP_XOR:   result = {{WIDTH{1'b0}}, s1_q.a ^ s1_q.b};
                OP_ADD:   result = {{(WIDTH-1){1'b0}}, sum};
                OP_MUL:   result = prod;
                OP_SHIFT: result = s1_q.direction ? {out_q[OW-2:0], s1_q.serial_in}
                                                  : {s1_q.serial_in, out_q[OW-1:1]};
                OP_ROT:   result = s1_q.direction ? {out_q[OW-2:0], out_q[OW-1]}
                                                  : {out_q[0], out_q[OW-1:1]};
                default:  result = '0;
            endcase
        end
    end

    always_comb begin : stage2_next
        out_d       = out_q;
        out_valid_d = s1_valid_q;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;
`ifdef ALSU_LED_BLINK_EN
        leds_d      = err_q ? ~leds_q : '0;
`else
        leds_d      = err_q ? LED_ON : '0;
`endif
        if (s1_valid_q) begin
            if (invalid) begin
                out_d  = '0;
                err_d  = 1'b1;
                leds_d = LED_ON;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end else begin
                out_d  = result;
                err_d  = 1'b0;
                leds_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            s1_q        <= '0;
            s1_valid_q  <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            leds_q      <= '0;
        end else begin
            s1_q        <= s1_d;
            s1_valid_q  <= s1_valid_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            leds_q      <= leds_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign leds      = leds_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_alsu_param.sv
// tb_alsu_param: directed-vector bench for alsu_param (WIDTH=3, FULL_ADDER=1, INPUT_PRIORITY=1).
// Expected leds patterns follow ALSU_LED_BLINK_EN when the bench is built with it defined.

module tb_alsu_param;

    localparam int WIDTH = 3;
    localparam int OW    = 2 * WIDTH;
    localparam int LED_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] a_i, b_i;
    logic [2:0]       opcode;
    logic             cin, serial_in, direction;
    logic             red_op_a, red_op_b, bypass_a, bypass_b;
    logic [OW-1:0]    out;
    logic             out_valid;
    logic [LED_W-1:0] leds;
    logic [7:0]       err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alsu_param #(
        .WIDTH          (WIDTH),
        .LED_W          (LED_W),
        .FULL_ADDER     (1),
        .INPUT_PRIORITY (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (a_i),
        .B         (b_i),
        .opcode    (opcode),
        .cin       (cin),
        .serial_in (serial_in),
        .direction (direction),
        .red_op_A  (red_op_a),
        .red_op_B  (red_op_b),
        .bypass_A  (bypass_a),
        .bypass_B  (bypass_b),
        .out       (out),
        .out_valid (out_valid),
        .leds      (leds),
        .err_cnt   (err_cnt)
    );

    // Advance to 1 time unit after the next rising edge; all sampling and driving happen there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op,
                         input logic c, input logic si, input logic dir,
                         input logic ra, input logic rb, input logic ba, input logic bb);
        in_valid  = 1'b1;
        a_i       = a;
        b_i       = b;
        opcode    = op;
        cin       = c;
        serial_in = si;
        direction = dir;
        red_op_a  = ra;
        red_op_b  = rb;
        bypass_a  = ba;
        bypass_b  = bb;
    endtask

    task automatic idle();
        drive(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(3'd7, 3'd7, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        n_cmp++; if (out !== 6'd0) begin n_bad++; $display("FAIL reset_out: got %0d expected 0", out); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        n_cmp++; if (leds !== 16'h0000) begin n_bad++; $display("FAIL reset_leds: got %h expected 0000", leds); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
        rst = 1'b0;
        idle();
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_release_valid0: got %0b expected 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_release_valid1: got %0b expected 0", out_valid); end
    endtask

    task automatic test_add();
        drive(3'd7, 3'd7, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL add_early_valid: got %0b expected 0", out_valid); end
        tick();
        n_cmp++; if (out !== 6'd15) begin n_bad++; $display("FAIL add_out: got %0d expected 15", out); end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid: got %0b expected 1", out_valid); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL add_err_cnt: got %0d expected 0", err_cnt); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL add_valid_pulse: got %0b expected 0", out_valid); end
        n_cmp++; if (out !== 6'd15) begin n_bad++; $display("FAIL add_hold: got %0d expected 15", out); end
    endtask

    task automatic test_mul();
        drive(3'd5, 3'd6, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(3'd7, 3'd7, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        n_cmp++; if (out !== 6'd30) begin n_bad++; $display("FAIL mul_5x6: got %0d expected 30", out); end
        tick();
        n_cmp++; if (out !== 6'd49) begin n_bad++; $display("FAIL mul_7x7: got %0d expected 49", out); end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mul_valid: got %0b expected 1", out_valid); end
        tick();
    endtask

    // Starts from out=49 (110001): rotate left -> 35, rotate right -> 49, shift right fill 0 -> 24.
    task automatic test_rotate();
        drive(3'd0, 3'd0, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(3'd0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (out !== 6'd35) begin n_bad++; $display("FAIL rot_left: got %0d expected 35", out); end
        tick();
        idle();
        n_cmp++; if (out !== 6'd49) begin n_bad++; $display("FAIL rot_right: got %0d expected 49", out); end
        tick();
        n_cmp++; if (out !== 6'd24) begin n_bad++; $display("FAIL shift_right: got %0d expected 24", out); end
        tick();
    endtask

    task automatic test_priority();
        drive(3'd3, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        drive(3'd3, 3'd4, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(3'd6, 3'd7, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (out !== 6'd5) begin n_bad++; $display("FAIL prio_bypass_both: got %0d expected 5", out); end
        tick();
        drive(3'd6, 3'd1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (out !== 6'd1) begin n_bad++; $display("FAIL prio_red_both: got %0d expected 1", out); end
        tick();
        idle();
        n_cmp++; if (out !== 6'd0) begin n_bad++; $display("FAIL red_and_a: got %0d expected 0", out); end
        tick();
        n_cmp++; if (out !== 6'd6) begin n_bad++; $display("FAIL bypass_over_shift: got %0d expected 6", out); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL prio_err_cnt: got %0d expected 0", err_cnt); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(3'd1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(3'd0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 1) begin
                n_cmp++; if (out !== 6'd1) begin n_bad++; $display("FAIL chain_bypass: got %0d expected 1", out); end
            end
            if (i == 2) begin
                n_cmp++; if (out !== 6'd2) begin n_bad++; $display("FAIL chain_shift1: got %0d expected 2", out); end
            end
            tick();
        end
        idle();
        n_cmp++; if (out !== 6'd4) begin n_bad++; $display("FAIL chain_shift2: got %0d expected 4", out); end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL chain_valid: got %0b expected 1", out_valid); end
        tick();
        n_cmp++; if (out !== 6'd8) begin n_bad++; $display("FAIL chain_shift3: got %0d expected 8", out); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL chain_valid_end: got %0b expected 0", out_valid); end
    endtask

    task automatic test_invalid();
        logic [LED_W-1:0] blink_lo;
`ifdef ALSU_LED_BLINK_EN
        blink_lo = 16'h0000;
`else
        blink_lo = 16'hFFFF;
`endif
        drive(3'd1, 3'd1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(3'd1, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        n_cmp++; if (out !== 6'd0) begin n_bad++; $display("FAIL inv_op6_out: got %0d expected 0", out); end
        n_cmp++; if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL inv_op6_cnt: got %0d expected 1", err_cnt); end
        n_cmp++; if (leds !== 16'hFFFF) begin n_bad++; $display("FAIL inv_leds0: got %h expected ffff", leds); end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL inv_valid: got %0b expected 1", out_valid); end
        tick();
        n_cmp++; if (err_cnt !== 8'd2) begin n_bad++; $display("FAIL inv_red_cnt: got %0d expected 2", err_cnt); end
        n_cmp++; if (leds !== 16'hFFFF) begin n_bad++; $display("FAIL inv_leds1: got %h expected ffff", leds); end
        tick();
        n_cmp++; if (leds !== blink_lo) begin n_bad++; $display("FAIL inv_leds2: got %h expected %h", leds, blink_lo); end
        tick();
        n_cmp++; if (leds !== 16'hFFFF) begin n_bad++; $display("FAIL inv_leds3: got %h expected ffff", leds); end
        tick();
        n_cmp++; if (leds !== blink_lo) begin n_bad++; $display("FAIL inv_leds4: got %h expected %h", leds, blink_lo); end
        drive(3'd5, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        n_cmp++; if (leds !== 16'hFFFF) begin n_bad++; $display("FAIL inv_leds5: got %h expected ffff", leds); end
        tick();
        n_cmp++; if (out !== 6'd1) begin n_bad++; $display("FAIL recover_out: got %0d expected 1", out); end
        n_cmp++; if (leds !== 16'h0000) begin n_bad++; $display("FAIL recover_leds: got %h expected 0000", leds); end
        n_cmp++; if (err_cnt !== 8'd2) begin n_bad++; $display("FAIL recover_cnt: got %0d expected 2", err_cnt); end
        tick();
        n_cmp++; if (leds !== 16'h0000) begin n_bad++; $display("FAIL recover_leds_hold: got %h expected 0000", leds); end
    endtask

    task automatic test_reset_midflight();
        drive(3'd2, 3'd3, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (out !== 6'd0) begin n_bad++; $display("FAIL mid_rst_out: got %0d expected 0", out); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %0b expected 0", out_valid); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL mid_rst_cnt: got %0d expected 0", err_cnt); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid1: got %0b expected 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid2: got %0b expected 0", out_valid); end
        n_cmp++; if (out !== 6'd0) begin n_bad++; $display("FAIL mid_rst_out2: got %0d expected 0", out); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            if (i == 255) begin
                n_cmp++; if (err_cnt !== 8'd254) begin n_bad++; $display("FAIL sat_254: got %0d expected 254", err_cnt); end
            end
            if (i == 256) begin
                n_cmp++; if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_255: got %0d expected 255", err_cnt); end
            end
            drive(3'd1, 3'd2, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle();
        tick();
        tick();
        n_cmp++; if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_hold: got %0d expected 255", err_cnt); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL sat_valid_end: got %0b expected 0", out_valid); end
`ifndef ALSU_LED_BLINK_EN
        n_cmp++; if (leds !== 16'hFFFF) begin n_bad++; $display("FAIL sat_leds: got %h expected ffff", leds); end
`endif
        drive(3'd5, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        n_cmp++; if (out !== 6'd6) begin n_bad++; $display("FAIL sat_xor_out: got %0d expected 6", out); end
        n_cmp++; if (leds !== 16'h0000) begin n_bad++; $display("FAIL sat_leds_clear: got %h expected 0000", leds); end
        n_cmp++; if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_cnt_after: got %0d expected 255", err_cnt); end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_add();
        test_mul();
        test_rotate();
        test_priority();
        test_back_to_back();
        test_invalid();
        test_reset_midflight();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alsu_param.md
# alsu_param

Parametrised, pipelined arithmetic/logic/shift unit that generalises the fixed 3-bit ALSU to WIDTH-bit operands. It adds a valid handshake, a configurable bypass/reduction priority, and a saturating error counter. It sits between the operand-capture logic and the LED/status board interface, and is the datapath core for the next board revision.

## Interface
- WIDTH, 3: operand width in bits (2..16).
- LED_W, 16: width of leds bus.
- FULL_ADDER, 1: 1 = add includes cin; 0 = cin ignored.
- INPUT_PRIORITY, 0: 0 = A wins when both A/B selects set; 1 = B wins.
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/control fields valid this cycle.
- A, B  input  WIDTH  operands.
- opcode  input  3  operation select.
- cin, serial_in, direction  input  1 each  carry-in, shift fill bit, 1 = left / 0 = right.
- red_op_A, red_op_B  input  1 each  reduction request on A / B.
- bypass_A, bypass_B  input  1 each  pass operand straight to out.
- out  output  2*WIDTH  registered result.
- out_valid  output  1  out updated this cycle.
- leds  output  LED_W  error indicator.
- err_cnt  output  8  saturating count of invalid operations.

## Operation
- Stage 1 captures all inputs when in_valid=1; s1_valid <= in_valid.
- Stage 2 computes from stage-1 registers when s1_valid=1 and updates out; otherwise out holds.
- Priority, highest first: invalid check, bypass, reduction, opcode.
- Invalid operation: opcode 6 or 7; or red_op_A|red_op_B with opcode not 0/1.
- Bypass: out = zero-extended selected operand. If both bypass bits are set, INPUT_PRIORITY picks the operand.
- Opcode 0 (AND), opcode 1 (XOR): bitwise on A,B. With reduction, out = reduction (&/^) of the selected operand in bit 0, zeros above. INPUT_PRIORITY resolves a reduction on both operands.
- Opcode 2: out = A + B (+ cin if FULL_ADDER), zero-extended. The carry lands in bit WIDTH.
- Opcode 3: out = A * B, full 2*WIDTH product.
- Opcode 4, shift by 1 on the current out:
  - left: {out[2W-2:0], serial_in}
  - right: {serial_in, out[2W-1:1]}
- Opcode 5, rotate by 1 on the current out; serial_in is ignored.
- Invalid result: out <= 0, err flag set, and err_cnt increments, holding at 255.
- The err flag clears on the next accepted valid operation.
- leds while err flag is clear: 0.
- Bypass overrides shift/rotate sources. A bypass with an invalid opcode is still invalid.

## Timing
- Latency: in_valid at edge N, result on out and out_valid=1 after edge N+2.
- Full throughput: one operation per cycle, no stalls, no backpressure.
- out_valid is a one-cycle pulse per accepted operation.
- Back-to-back shifts use the out value produced by the immediately preceding operation, so a chain of k shifts moves k bits.
- Reset values: out=0, out_valid=0, leds=0, err_cnt=0, stage-1 registers=0, s1_valid=0, err flag=0.
- Reset mid-operation discards in-flight stage-1 data. out_valid stays 0 on the cycle after reset deasserts, even if in_valid was high during reset.
- rst has priority over in_valid on the same edge.

## Configuration
- ALSU_LED_BLINK_EN defined:
  - While the err flag is set, leds toggles every clock between all-ones and all-zeros.
  - The first cycle after the error is all-ones.
- Not defined: leds is held at all-ones while the err flag is set.
- In both cases leds returns to 0 on the cycle out_valid reports the next valid result.

## Test plan
- Reset then add, WIDTH=3, FULL_ADDER=1: A=7, B=7, cin=1, opcode=2, in_valid pulse -> two edges later out=15, out_valid=1 for one cycle; err_cnt=0.
- Multiply: A=5, B=6, opcode=3 -> out=30.
- Shift chain: bypass_A with A=1 gives out=1. Then opcode=4, direction=1, serial_in=0 on three consecutive cycles -> out=2, 4, 8 on consecutive cycles.
- Invalid: opcode=6, then red_op_A=1 with opcode=2 -> out=0, err_cnt=1 then 2.
  - With ALSU_LED_BLINK_EN: leds alternates 0xFFFF/0x0000 until a valid opcode=0 op.
  - Without the macro: leds stays 0xFFFF.
- Priority with INPUT_PRIORITY=1: bypass_A=bypass_B=1, A=3, B=5 -> out=5; red_op_A=red_op_B=1, opcode=1, A=3, B=4 -> out=1.
- Reset mid-flight: in_valid with opcode=2, rst asserted the next edge -> out=0 and no out_valid pulse. Drive 300 invalid ops -> err_cnt saturates at 255.
